// File: rtl/prbs_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
// Shared PRBS7 (x^7 + x^6 + 1) definitions used by the receive-side BER checker
// and the transmit-side PRBS generator.
//   prbs_state_t : checker lock state (SEARCH / LOCKED)
//   PRBS_W       : LFSR width
//   PRBS_TAP_HI  : older feedback tap (x^7 term)
//   PRBS_TAP_LO  : newer feedback tap (x^6 term)
//   prbs7_fb()   : next PRBS bit for a given LFSR state
// -----------------------------------------------------------------------------
package prbs_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_state_t;

  localparam int PRBS_W      = 7;
  localparam int PRBS_TAP_HI = 6;
  localparam int PRBS_TAP_LO = 5;

  // The LFSR shifts left with the newest bit in [0], so [6] and [5] hold the
  // bits from 7 and 6 positions back.
  function automatic logic prbs7_fb(input logic [PRBS_W-1:0] state);
    return state[PRBS_TAP_HI] ^ state[PRBS_TAP_LO];
  endfunction

endpackage

// File: rtl/prbs7_next.sv
// -----------------------------------------------------------------------------
// prbs7_next
// Pure combinational next-bit function for PRBS7. Shared with the generator so
// both ends agree on the polynomial and tap order.
// Ports:
//   lfsr     in  [6:0]  current LFSR contents (newest bit in [0])
//   next_bit out        bit the sequence produces next
// -----------------------------------------------------------------------------
module prbs7_next
  import prbs_pkg::*;
(
  input  logic [PRBS_W-1:0] lfsr,
  output logic              next_bit
);

  assign next_bit = prbs7_fb(lfsr);

endmodule

// File: rtl/prbs_ber_checker.sv
// -----------------------------------------------------------------------------
// prbs_ber_checker
// Self-synchronising PRBS7 bit-error-rate checker. In SEARCH the LFSR is filled
// from the incoming stream and lock is declared after LOCK_THRESH consecutive
// predicted bits. In LOCKED the LFSR free-runs and every valid bit is counted,
// mismatches are counted as errors and flagged on err_pulse.
//
// Build option: define PRBS_CHK_LOL_EN to add loss-of-lock detection (LOL_ERR
// errors inside one LOL_WIN-bit window return the checker to SEARCH). Without
// it the checker stays LOCKED until reset.
//
// Ports:
//   clk           in   clock, rising edge
//   rstn          in   asynchronous active-low reset
//   data_in       in   serial data bit
//   data_in_valid in   data_in qualifier (gaps allowed)
//   clear         in   synchronous zeroing of bit_count / err_count
//   locked        out  high while LOCKED
//   bit_count     out  valid bits checked while locked (saturating)
//   err_count     out  mismatching bits while locked (saturating)
//   err_pulse     out  one-cycle pulse per counted error
// -----------------------------------------------------------------------------
module prbs_ber_checker
  import prbs_pkg::*;
#(
  parameter int BIT_CNT_W   = 48,
  parameter int ERR_CNT_W   = 32,
  parameter int LOCK_THRESH = 16,
  parameter int LOL_WIN     = 64,
  parameter int LOL_ERR     = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 data_in,
  input  logic                 data_in_valid,
  input  logic                 clear,
  output logic                 locked,
  output logic [BIT_CNT_W-1:0] bit_count,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 err_pulse
);

  localparam int         MATCH_W   = $clog2(LOCK_THRESH + 1);
  localparam logic [2:0] FILL_FULL = 3'(PRBS_W);

  prbs_state_t          state_reg, state_next;
  logic [PRBS_W-1:0]    lfsr_reg, lfsr_next;
  logic [2:0]           fill_reg, fill_next;
  logic [MATCH_W-1:0]   match_reg, match_next;
  logic [BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;
  logic                 err_pulse_reg, err_pulse_next;
  logic                 expected;
  logic                 mismatch;

`ifdef PRBS_CHK_LOL_EN
  localparam int WIN_W  = $clog2(LOL_WIN + 1);
  localparam int WERR_W = $clog2(LOL_ERR + 1);

  logic [WIN_W-1:0]  win_bits_reg, win_bits_next;
  logic [WERR_W-1:0] win_errs_reg, win_errs_next;
`else
  // Window sizing has no effect when loss-of-lock detection is not built in.
  logic lol_cfg_unused;
  assign lol_cfg_unused = (LOL_WIN > 0) && (LOL_ERR > 0);
`endif

  prbs7_next u_prbs7_next (
    .lfsr     (lfsr_reg),
    .next_bit (expected)
  );

  assign mismatch = data_in ^ expected;

  always_comb begin
    state_next     = state_reg;
    lfsr_next      = lfsr_reg;
    fill_next      = fill_reg;
    match_next     = match_reg;
    bit_cnt_next   = bit_cnt_reg;
    err_cnt_next   = err_cnt_reg;
    err_pulse_next = 1'b0;
`ifdef PRBS_CHK_LOL_EN
    win_bits_next  = win_bits_reg;
    win_errs_next  = win_errs_reg;
`endif

    if (clear) begin
      bit_cnt_next = '0;
      err_cnt_next = '0;
      // The bit is not counted, but a locked LFSR must still step so it stays
      // aligned with the incoming stream.
      if (data_in_valid && state_reg == LOCKED) begin
        lfsr_next = {lfsr_reg[PRBS_W-2:0], expected};
      end
    end else if (data_in_valid) begin
      case (state_reg)
        SEARCH: begin
          lfsr_next = {lfsr_reg[PRBS_W-2:0], data_in};
          if (fill_reg != FILL_FULL) begin
            fill_next = fill_reg + 3'd1;
          end else if (lfsr_reg == '0 || mismatch) begin
            // An all-zero LFSR predicts zeros forever; never let it lock.
            match_next = '0;
          end else if (match_reg == MATCH_W'(LOCK_THRESH - 1)) begin
            state_next = LOCKED;
            match_next = '0;
`ifdef PRBS_CHK_LOL_EN
            win_bits_next = '0;
            win_errs_next = '0;
`endif
          end else begin
            match_next = match_reg + MATCH_W'(1);
          end
        end

        LOCKED: begin
          lfsr_next = {lfsr_reg[PRBS_W-2:0], expected};
          if (bit_cnt_reg != '1) begin
            bit_cnt_next = bit_cnt_reg + BIT_CNT_W'(1);
          end
          if (mismatch) begin
            err_pulse_next = 1'b1;
            if (err_cnt_reg != '1) begin
              err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
            end
          end
`ifdef PRBS_CHK_LOL_EN
          if (mismatch && win_errs_reg == WERR_W'(LOL_ERR - 1)) begin
            state_next    = SEARCH;
            fill_next     = '0;
            match_next    = '0;
            win_bits_next = '0;
            win_errs_next = '0;
          end else if (win_bits_reg == WIN_W'(LOL_WIN - 1)) begin
            win_bits_next = '0;
            win_errs_next = '0;
          end else begin
            win_bits_next = win_bits_reg + WIN_W'(1);
            if (mismatch) begin
              win_errs_next = win_errs_reg + WERR_W'(1);
            end
          end
`endif
        end

        default: state_next = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= SEARCH;
      lfsr_reg      <= '0;
      fill_reg      <= '0;
      match_reg     <= '0;
      bit_cnt_reg   <= '0;
      err_cnt_reg   <= '0;
      err_pulse_reg <= 1'b0;
`ifdef PRBS_CHK_LOL_EN
      win_bits_reg  <= '0;
      win_errs_reg  <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      lfsr_reg      <= lfsr_next;
      fill_reg      <= fill_next;
      match_reg     <= match_next;
      bit_cnt_reg   <= bit_cnt_next;
      err_cnt_reg   <= err_cnt_next;
      err_pulse_reg <= err_pulse_next;
`ifdef PRBS_CHK_LOL_EN
      win_bits_reg  <= win_bits_next;
      win_errs_reg  <= win_errs_next;
`endif
    end
  end

  // state_reg is a single flop, so locked is a registered output.
  assign locked    = (state_reg == LOCKED);
  assign bit_count = bit_cnt_reg;
  assign err_count = err_cnt_reg;
  assign err_pulse = err_pulse_reg;

endmodule

// File: tb/tb_prbs_ber_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_ber_checker
// Directed bench for prbs_ber_checker. A default-parameter instance and a
// narrow-counter instance (BIT_CNT_W=8, ERR_CNT_W=2) share one stimulus stream.
// A phase table drives bulk traffic; hand-written sequences cover clear, the
// single-error pulse, and the error burst (behaviour depends on
// PRBS_CHK_LOL_EN).
// -----------------------------------------------------------------------------
module tb_prbs_ber_checker;

  localparam int MODE_ZERO = 0;
  localparam int MODE_PRBS = 1;
  localparam int MODE_INV  = 2;
  localparam int NPH       = 5;

  typedef struct {
    logic   rst;
    int     mode;
    int     nbits;
    int     gap;
    int     lock_at;
    logic   exp_locked;
    longint exp_bc;
    longint exp_ec;
  } phase_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        data_in = 1'b0;
  logic        data_in_valid = 1'b0;
  logic        clear = 1'b0;

  logic        locked;
  logic [47:0] bit_count;
  logic [31:0] err_count;
  logic        err_pulse;

  logic        locked_w2;
  logic [7:0]  bit_count_w2;
  logic [1:0]  err_count_w2;
  logic        err_pulse_w2;

  int          checks = 0;
  int          errors = 0;
  logic [6:0]  gen;
  phase_t      phases [NPH];

  always #5 clk = ~clk;

  prbs_ber_checker dut (
    .clk           (clk),
    .rstn          (rstn),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .clear         (clear),
    .locked        (locked),
    .bit_count     (bit_count),
    .err_count     (err_count),
    .err_pulse     (err_pulse)
  );

  prbs_ber_checker #(
    .BIT_CNT_W (8),
    .ERR_CNT_W (2)
  ) dut_w2 (
    .clk           (clk),
    .rstn          (rstn),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .clear         (clear),
    .locked        (locked_w2),
    .bit_count     (bit_count_w2),
    .err_count     (err_count_w2),
    .err_pulse     (err_pulse_w2)
  );

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  function automatic longint sat(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Transmit-side PRBS7 reference sequence, seeded 7'h7F.
  task automatic gen_bit(output logic b);
    b   = gen[6] ^ gen[5];
    gen = {gen[5:0], b};
  endtask

  // One valid bit: driven just after a rising edge, outputs observed 1 ns
  // after the edge that samples it.
  task automatic send(input logic d, input logic clr);
    data_in       = d;
    data_in_valid = 1'b1;
    clear         = clr;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    clear         = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_prbs(input int n, input logic inv);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen_bit(b);
      send(b ^ inv, 1'b0);
    end
  endtask

  // Reset is asserted between clock edges and checked before any edge, so the
  // outputs must clear asynchronously.
  task automatic do_reset(input string tag);
    rstn = 1'b0;
    #2;
    chk($sformatf("%s reset locked", tag), locked, 0);
    chk($sformatf("%s reset bit_count", tag), bit_count, 0);
    chk($sformatf("%s reset err_count", tag), err_count, 0);
    chk($sformatf("%s reset err_pulse", tag), err_pulse, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    gen  = 7'h7F;
  endtask

  initial begin
    logic   b;
    logic   exp_l;
    logic   exp_p;
    longint exp_e;

    //            rst   mode       n    gap lock locked bc   ec
    phases[0] = '{1'b1, MODE_ZERO, 100, 0,  0,   1'b0,  0,   0};
    phases[1] = '{1'b1, MODE_PRBS, 200, 0,  23,  1'b1,  177, 0};
    phases[2] = '{1'b1, MODE_PRBS, 200, 2,  23,  1'b1,  177, 0};
    phases[3] = '{1'b0, MODE_PRBS, 100, 0,  0,   1'b1,  277, 0};
    phases[4] = '{1'b0, MODE_INV,  5,   0,  0,   1'b1,  282, 5};

    gen = 7'h7F;
    #1;

    for (int p = 0; p < NPH; p++) begin
      if (phases[p].rst) do_reset($sformatf("ph%0d", p));
      for (int i = 1; i <= phases[p].nbits; i++) begin
        if (phases[p].mode == MODE_ZERO) begin
          b = 1'b0;
        end else begin
          gen_bit(b);
          b = b ^ (phases[p].mode == MODE_INV);
        end
        send(b, 1'b0);
        if (phases[p].mode != MODE_PRBS || i <= 30) begin
          chk($sformatf("ph%0d bit%0d err_pulse", p, i), err_pulse,
              (phases[p].mode == MODE_INV) ? 1 : 0);
        end
        if (phases[p].lock_at != 0 &&
            (i == phases[p].lock_at - 1 || i == phases[p].lock_at)) begin
          chk($sformatf("ph%0d bit%0d locked", p, i), locked,
              (i == phases[p].lock_at) ? 1 : 0);
        end
        idle(phases[p].gap);
      end
      chk($sformatf("ph%0d locked", p), locked, phases[p].exp_locked);
      chk($sformatf("ph%0d bit_count", p), bit_count, phases[p].exp_bc);
      chk($sformatf("ph%0d err_count", p), err_count, phases[p].exp_ec);
      chk($sformatf("ph%0d w2 locked", p), locked_w2, phases[p].exp_locked);
      chk($sformatf("ph%0d w2 bit_count", p), bit_count_w2, sat(phases[p].exp_bc, 255));
      chk($sformatf("ph%0d w2 err_count", p), err_count_w2, sat(phases[p].exp_ec, 3));
    end

    // clear together with an erroneous bit: nothing counted, no pulse, lock kept
    gen_bit(b);
    send(~b, 1'b1);
    chk("clr err_count", err_count, 0);
    chk("clr bit_count", bit_count, 0);
    chk("clr err_pulse", err_pulse, 0);
    chk("clr locked", locked, 1);
    chk("clr w2 err_count", err_count_w2, 0);
    send_prbs(10, 1'b0);
    chk("post-clr bit_count", bit_count, 10);
    chk("post-clr err_count", err_count, 0);
    chk("post-clr locked", locked, 1);

    // single error 50 bits after lock
    do_reset("err1");
    send_prbs(23, 1'b0);
    chk("err1 locked", locked, 1);
    send_prbs(49, 1'b0);
    chk("err1 pre err_pulse", err_pulse, 0);
    send_prbs(1, 1'b1);
    chk("err1 err_pulse", err_pulse, 1);
    chk("err1 err_count", err_count, 1);
    chk("err1 bit_count", bit_count, 50);
    idle(1);
    chk("err1 pulse width", err_pulse, 0);
    send_prbs(1, 1'b0);
    chk("err1 next err_pulse", err_pulse, 0);
    chk("err1 err_count hold", err_count, 1);
    chk("err1 locked hold", locked, 1);

    // 16-bit error burst after a fresh lock, then clean traffic
    do_reset("burst");
    send_prbs(23, 1'b0);
    chk("burst lock", locked, 1);
    for (int k = 1; k <= 16; k++) begin
      send_prbs(1, 1'b1);
`ifdef PRBS_CHK_LOL_EN
      exp_l = (k < 8);
      exp_p = (k <= 8);
      exp_e = (k < 8) ? k : 8;
`else
      exp_l = 1'b1;
      exp_p = 1'b1;
      exp_e = k;
`endif
      chk($sformatf("burst k%0d locked", k), locked, exp_l);
      chk($sformatf("burst k%0d err_pulse", k), err_pulse, exp_p);
      chk($sformatf("burst k%0d err_count", k), err_count, exp_e);
    end
    for (int j = 1; j <= 23; j++) begin
      send_prbs(1, 1'b0);
`ifdef PRBS_CHK_LOL_EN
      exp_l = (j == 23);
`else
      exp_l = 1'b1;
`endif
      chk($sformatf("relock j%0d locked", j), locked, exp_l);
      chk($sformatf("relock j%0d err_pulse", j), err_pulse, 0);
    end
`ifdef PRBS_CHK_LOL_EN
    chk("relock err_count", err_count, 8);
    chk("relock bit_count", bit_count, 8);
`else
    chk("burst final err_count", err_count, 16);
    chk("burst final bit_count", bit_count, 39);
    chk("burst w2 err_count", err_count_w2, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
